// File: rtl/sys_arr_pkg.sv
// Shared types for the systolic-array issue path: register/row types and feeder FSM states.
package sys_arr_pkg;

  localparam int DEF_VEGGIEREGS = 256;
  localparam int DEF_DATA_W     = 512;
  localparam int DEF_REG_W      = $clog2(DEF_VEGGIEREGS);

  typedef logic [DEF_DATA_W-1:0] row_t;
  typedef logic [DEF_REG_W-1:0]  reg_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    PUSH,
    TAG
  } feeder_state_t;

endpackage

// File: rtl/gsau_operand_feeder.sv
// Streams ROWS consecutive vector registers into the SA input FIFO, then emits the destination tag.
// Optional stall counter port enabled by GSAU_FEEDER_PERF_EN.
module gsau_operand_feeder
  import sys_arr_pkg::*;
#(
  parameter int VEGGIEREGS = DEF_VEGGIEREGS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ROWS       = 4,
  localparam int REG_W     = $clog2(VEGGIEREGS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [REG_W-1:0]  issue_vs,
  input  logic [REG_W-1:0]  issue_vdst,
  output logic              rf_ren,
  output logic [REG_W-1:0]  rf_raddr,
  input  logic              rf_rvalid,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              sa_in_valid,
  output logic [DATA_W-1:0] sa_in_data,
  input  logic              sa_fifo_has_space,
  output logic              sb_nvalid,
  output logic [REG_W-1:0]  sb_nvdst,
  output logic              busy
`ifdef GSAU_FEEDER_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  feeder_state_t     state_reg, state_next;
  logic [REG_W-1:0]  base_reg;
  logic [REG_W-1:0]  dst_reg;
  logic [REG_W-1:0]  tag_reg;
  logic [CNT_W-1:0]  row_cnt_reg;
  logic [DATA_W-1:0] data_reg;
  logic              xfer;

  assign xfer = (state_reg == PUSH) && sa_fifo_has_space;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (issue_valid) state_next = REQ;
      REQ:  state_next = WAIT;
      WAIT: if (rf_rvalid) state_next = PUSH;
      PUSH: if (sa_fifo_has_space) state_next = (row_cnt_reg == LAST_ROW) ? TAG : REQ;
      TAG:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data is only captured in WAIT; stray rf_rvalid in other states is dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      base_reg    <= '0;
      dst_reg     <= '0;
      tag_reg     <= '0;
      row_cnt_reg <= '0;
      data_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && issue_valid) begin
        base_reg    <= issue_vs;
        dst_reg     <= issue_vdst;
        row_cnt_reg <= '0;
      end
      if (state_reg == WAIT && rf_rvalid) data_reg <= rf_rdata;
      if (xfer) begin
        if (row_cnt_reg == LAST_ROW) tag_reg <= dst_reg;
        else row_cnt_reg <= row_cnt_reg + 1'b1;
      end
    end
  end

  assign issue_ready = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign rf_ren      = (state_reg == REQ);
  assign rf_raddr    = (state_reg == REQ) ? base_reg + REG_W'(row_cnt_reg) : '0;
  assign sa_in_valid = (state_reg == PUSH);
  assign sa_in_data  = data_reg;
  assign sb_nvalid   = (state_reg == TAG);
  assign sb_nvdst    = tag_reg;

`ifdef GSAU_FEEDER_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RST) stall_cnt_reg <= '0;
    else if (state_reg == PUSH && !sa_fifo_has_space && stall_cnt_reg != '1)
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_gsau_operand_feeder.sv
// Directed bench for gsau_operand_feeder: table of instructions plus reset-abort and back-to-back sequences.
module tb_gsau_operand_feeder;
  import sys_arr_pkg::*;

  localparam int ROWS   = 4;
  localparam int DATA_W = DEF_DATA_W;

  logic     CLK = 1'b0;
  logic     RST;
  logic     issue_valid;
  logic     issue_ready;
  reg_idx_t issue_vs;
  reg_idx_t issue_vdst;
  logic     rf_ren;
  reg_idx_t rf_raddr;
  logic     rf_rvalid = 1'b0;
  row_t     rf_rdata = '0;
  logic     sa_in_valid;
  row_t     sa_in_data;
  logic     sa_fifo_has_space = 1'b1;
  logic     sb_nvalid;
  reg_idx_t sb_nvdst;
  logic     busy;
`ifdef GSAU_FEEDER_PERF_EN
  logic [31:0] stall_cycles;
`endif

  gsau_operand_feeder #(.ROWS(ROWS)) dut (
    .CLK(CLK), .RST(RST),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_vs(issue_vs), .issue_vdst(issue_vdst),
    .rf_ren(rf_ren), .rf_raddr(rf_raddr),
    .rf_rvalid(rf_rvalid), .rf_rdata(rf_rdata),
    .sa_in_valid(sa_in_valid), .sa_in_data(sa_in_data),
    .sa_fifo_has_space(sa_fifo_has_space),
    .sb_nvalid(sb_nvalid), .sb_nvdst(sb_nvdst),
    .busy(busy)
`ifdef GSAU_FEEDER_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic row_t rdata(input reg_idx_t a, input int s);
    logic [15:0] s16;
    s16 = s[15:0];
    return {16{a, 8'hC3, s16}};
  endfunction

  // Register file and FIFO model, both updated just after each rising edge.
  int       lat = 1;
  int       salt = 0;
  bit       spur_req = 1'b0;
  int       rd_cnt = -1;
  reg_idx_t rd_addr;
  bit       hold_space = 1'b0;
  int       stall_row = -1;
  int       stall_left = 0;
  int       push_n = 0;

  always @(posedge CLK) begin
    #1;
    rf_rvalid = 1'b0;
    rf_rdata  = '0;
    if (rd_cnt > 0) rd_cnt--;
    if (rd_cnt == 0) begin
      rf_rvalid = 1'b1;
      rf_rdata  = rdata(rd_addr, salt);
      rd_cnt    = -1;
    end else if (spur_req) begin
      rf_rvalid = 1'b1;
      rf_rdata  = {16{32'hDEADBEEF}};
      spur_req  = 1'b0;
    end
    if (rf_ren) begin
      rd_cnt  = lat;
      rd_addr = rf_raddr;
    end
    if (hold_space) sa_fifo_has_space = 1'b0;
    else if (sa_in_valid && push_n == stall_row && stall_left > 0) begin
      sa_fifo_has_space = 1'b0;
      stall_left--;
    end else sa_fifo_has_space = 1'b1;
  end

  // Monitor: records reads, pushes, handshakes and tags; checks PUSH hold stability.
  reg_idx_t addr_q[$];
  row_t     data_q[$];
  int       hs_q[$];
  int       sb_cyc[$];
  reg_idx_t sb_dst_q[$];
  logic     pv = 1'b0;
  logic     pxfer = 1'b0;
  row_t     pd = '0;

  always @(negedge CLK) begin
    if (RST) begin
      pv = 1'b0;
    end else begin
      if (issue_valid && issue_ready) hs_q.push_back(cyc);
      if (rf_ren) addr_q.push_back(rf_raddr);
      if (pv && !pxfer) begin
        check("hold_valid", DATA_W'(sa_in_valid), DATA_W'(1));
        check("hold_data", sa_in_data, pd);
      end
      if (sa_in_valid && sa_fifo_has_space) begin
        data_q.push_back(sa_in_data);
        push_n++;
      end
      if (sb_nvalid) begin
        sb_cyc.push_back(cyc);
        sb_dst_q.push_back(sb_nvdst);
      end
      pv    = sa_in_valid;
      pxfer = sa_in_valid && sa_fifo_has_space;
      pd    = sa_in_data;
    end
  end

  task automatic clear_logs();
    addr_q.delete();
    data_q.delete();
    hs_q.delete();
    sb_cyc.delete();
    sb_dst_q.delete();
    push_n = 0;
  endtask

  task automatic wait_sb(input int n, input string name);
    int k;
    k = 0;
    while (sb_cyc.size() < n && k < 300) begin
      tick();
      k++;
    end
    check(name, DATA_W'(sb_cyc.size()), DATA_W'(n));
  endtask

  typedef struct {
    reg_idx_t vs;
    reg_idx_t vdst;
    int       lat;
    bit       spur;
    int       srow;
    int       slen;
    int       exp_lat;
  } vec_t;

  vec_t vecs[4];
  int   exp_stall;

  initial begin
    vecs[0] = '{vs: 8'h10, vdst: 8'h0A, lat: 1, spur: 1'b0, srow: -1, slen: 0, exp_lat: 14};
    vecs[1] = '{vs: 8'h20, vdst: 8'h33, lat: 1, spur: 1'b0, srow: 1,  slen: 5, exp_lat: 19};
    vecs[2] = '{vs: 8'hFE, vdst: 8'h44, lat: 1, spur: 1'b0, srow: -1, slen: 0, exp_lat: 14};
    vecs[3] = '{vs: 8'h05, vdst: 8'h5B, lat: 3, spur: 1'b1, srow: -1, slen: 0, exp_lat: 22};
    exp_stall = 0;

    RST = 1'b1;
    issue_valid = 1'b0;
    issue_vs = '0;
    issue_vdst = '0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    check("rst_issue_ready", DATA_W'(issue_ready), DATA_W'(1));
    check("rst_busy", DATA_W'(busy), DATA_W'(0));
    check("rst_rf_ren", DATA_W'(rf_ren), DATA_W'(0));
    check("rst_rf_raddr", DATA_W'(rf_raddr), DATA_W'(0));
    check("rst_sa_in_valid", DATA_W'(sa_in_valid), DATA_W'(0));
    check("rst_sa_in_data", sa_in_data, DATA_W'(0));
    check("rst_sb_nvalid", DATA_W'(sb_nvalid), DATA_W'(0));
    check("rst_sb_nvdst", DATA_W'(sb_nvdst), DATA_W'(0));
`ifdef GSAU_FEEDER_PERF_EN
    check("rst_stall_cycles", DATA_W'(stall_cycles), DATA_W'(0));
`endif

    for (int i = 0; i < 4; i++) begin
      clear_logs();
      lat        = vecs[i].lat;
      salt       = i + 1;
      stall_row  = vecs[i].srow;
      stall_left = vecs[i].slen;
      if (vecs[i].spur) begin
        spur_req = 1'b1;
        tick();
        tick();
      end
      issue_vs    = vecs[i].vs;
      issue_vdst  = vecs[i].vdst;
      issue_valid = 1'b1;
      tick();
      issue_valid = 1'b0;
      wait_sb(1, $sformatf("v%0d_sb_seen", i));
      repeat (3) tick();
      check($sformatf("v%0d_nreads", i), DATA_W'(addr_q.size()), DATA_W'(ROWS));
      check($sformatf("v%0d_npush", i), DATA_W'(data_q.size()), DATA_W'(ROWS));
      for (int j = 0; j < ROWS; j++) begin
        reg_idx_t ea;
        ea = vecs[i].vs + reg_idx_t'(j);
        if (j < addr_q.size()) check($sformatf("v%0d_addr%0d", i, j), DATA_W'(addr_q[j]), DATA_W'(ea));
        if (j < data_q.size()) check($sformatf("v%0d_data%0d", i, j), data_q[j], rdata(ea, salt));
      end
      check($sformatf("v%0d_ntag", i), DATA_W'(sb_cyc.size()), DATA_W'(1));
      if (sb_cyc.size() > 0 && hs_q.size() > 0) begin
        check($sformatf("v%0d_tag", i), DATA_W'(sb_dst_q[0]), DATA_W'(vecs[i].vdst));
        check($sformatf("v%0d_latency", i), DATA_W'(sb_cyc[0] - hs_q[0] + 1), DATA_W'(vecs[i].exp_lat));
      end
      check($sformatf("v%0d_nvdst_held", i), DATA_W'(sb_nvdst), DATA_W'(vecs[i].vdst));
      exp_stall += vecs[i].slen;
`ifdef GSAU_FEEDER_PERF_EN
      check($sformatf("v%0d_stall_cycles", i), DATA_W'(stall_cycles), DATA_W'(exp_stall));
`endif
    end

    // Abort while the first row sits in PUSH.
    clear_logs();
    lat = 1;
    salt = 9;
    hold_space = 1'b1;
    issue_vs = 8'h60;
    issue_vdst = 8'h77;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    for (int k = 0; k < 50 && !sa_in_valid; k++) tick();
    check("abort_in_push", DATA_W'(sa_in_valid), DATA_W'(1));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    hold_space = 1'b0;
    check("abort_issue_ready", DATA_W'(issue_ready), DATA_W'(1));
    check("abort_busy", DATA_W'(busy), DATA_W'(0));
    check("abort_sa_in_valid", DATA_W'(sa_in_valid), DATA_W'(0));
`ifdef GSAU_FEEDER_PERF_EN
    check("abort_stall_cleared", DATA_W'(stall_cycles), DATA_W'(0));
`endif
    repeat (40) tick();
    check("abort_no_tag", DATA_W'(sb_cyc.size()), DATA_W'(0));
    check("abort_no_push", DATA_W'(data_q.size()), DATA_W'(0));

    // issue_valid held high: second accept must follow the first tag by one cycle.
    clear_logs();
    lat = 1;
    salt = 11;
    issue_vs = 8'h40;
    issue_vdst = 8'h11;
    issue_valid = 1'b1;
    for (int k = 0; k < 300 && sb_cyc.size() < 2; k++) begin
      tick();
      if (hs_q.size() >= 2) issue_valid = 1'b0;
    end
    issue_valid = 1'b0;
    check("b2b_ntag", DATA_W'(sb_cyc.size()), DATA_W'(2));
    check("b2b_naccept", DATA_W'(hs_q.size()), DATA_W'(2));
    if (hs_q.size() >= 2 && sb_cyc.size() >= 2) begin
      check("b2b_accept_after_tag", DATA_W'(hs_q[1]), DATA_W'(sb_cyc[0] + 1));
      check("b2b_latency2", DATA_W'(sb_cyc[1] - hs_q[1] + 1), DATA_W'(14));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
